// File: rtl/usb_nrzi_tx.sv
// rtl/usb_nrzi_tx.sv - USB LS/FS line transmitter: word handshake, bit stuffing, NRZI, timed EOP
module usb_nrzi_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 8,
    parameter int STUFF_LEN    = 6,
    parameter int EOP_SE0_BITS = 2
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    input  logic                  tx_last,
    output logic                  tx_ready,
    output logic                  tx_busy,
    output logic                  tx_err,
    output logic                  d_plus,
    output logic                  d_minus
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam int OW = $clog2(STUFF_LEN + 1);
    localparam int EW = (EOP_SE0_BITS > 1) ? $clog2(EOP_SE0_BITS) : 1;

    localparam logic [CW-1:0] TICK_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LEN);
    localparam logic [EW-1:0] SE0_MAX  = EW'(EOP_SE0_BITS - 1);

    typedef enum logic [2:0] {IDLE, SEND, STUFF, EOP_SE0, EOP_J} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]         bits_left_q, bits_left_d;
    logic [OW-1:0]         ones_q, ones_d;
    logic [EW-1:0]         eop_cnt_q, eop_cnt_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                  hold_full_q, hold_full_d;
    logic                  hold_last_q, hold_last_d;
    logic                  cur_last_q, cur_last_d;
    logic                  last_seen_q, last_seen_d;
    logic                  first_q, first_d;
    logic                  nrzi_q, nrzi_d;
    logic                  tx_err_q, tx_err_d;
    logic                  d_plus_q, d_plus_d;
    logic                  d_minus_q, d_minus_d;

    logic bit_tick, emit, accept, send_bit, data_bit, line_upd;

    assign bit_tick = (cnt_q == TICK_MAX);
    // The very first bit of a packet goes out one clock after acceptance.
    assign emit     = first_q || bit_tick;
    assign tx_ready = !hold_full_q && !last_seen_q &&
                      (state_q == IDLE || state_q == SEND || state_q == STUFF);
    assign accept   = tx_valid && tx_ready;
    assign tx_busy  = (state_q != IDLE);
    assign tx_err   = tx_err_q;
    assign d_plus   = d_plus_q;
    assign d_minus  = d_minus_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bits_left_d = bits_left_q;
        ones_d      = ones_q;
        eop_cnt_d   = eop_cnt_q;
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;
        hold_last_d = hold_last_q;
        cur_last_d  = cur_last_q;
        last_seen_d = last_seen_q;
        first_d     = first_q;
        nrzi_d      = nrzi_q;
        tx_err_d    = 1'b0;
        d_plus_d    = d_plus_q;
        d_minus_d   = d_minus_q;
        send_bit    = 1'b0;
        data_bit    = 1'b0;
        line_upd    = 1'b0;

        if (state_q == IDLE || first_q || bit_tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d     = tx_data;
                    bits_left_d = BW'(DATA_WIDTH);
                    cur_last_d  = tx_last;
                    last_seen_d = tx_last;
                    ones_d      = '0;
                    first_d     = 1'b1;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (emit) begin
                    first_d = 1'b0;
                    if (bits_left_q != '0) begin
                        send_bit    = 1'b1;
                        data_bit    = shift_q[0];
                        shift_d     = shift_q >> 1;
                        bits_left_d = bits_left_q - BW'(1);
                    end else if (hold_full_q) begin
                        // Next word follows with no gap bit time.
                        send_bit    = 1'b1;
                        data_bit    = hold_data_q[0];
                        shift_d     = hold_data_q >> 1;
                        bits_left_d = BW'(DATA_WIDTH - 1);
                        hold_full_d = 1'b0;
                        cur_last_d  = hold_last_q;
                    end else begin
                        tx_err_d  = !cur_last_q;
                        state_d   = EOP_SE0;
                        eop_cnt_d = '0;
                        d_plus_d  = 1'b0;
                        d_minus_d = 1'b0;
                    end
                end
            end
            STUFF: begin
                if (emit) begin
                    nrzi_d   = !nrzi_q;
                    ones_d   = '0;
                    line_upd = 1'b1;
                    state_d  = SEND;
                end
            end
            EOP_SE0: begin
                if (bit_tick) begin
                    if (eop_cnt_q == SE0_MAX) begin
                        state_d   = EOP_J;
                        nrzi_d    = 1'b1;
                        d_plus_d  = 1'b1;
                        d_minus_d = 1'b0;
                    end else begin
                        eop_cnt_d = eop_cnt_q + EW'(1);
                    end
                end
            end
            EOP_J: begin
                if (bit_tick) begin
                    state_d     = IDLE;
                    shift_d     = '0;
                    bits_left_d = '0;
                    ones_d      = '0;
                    eop_cnt_d   = '0;
                    hold_data_d = '0;
                    hold_full_d = 1'b0;
                    hold_last_d = 1'b0;
                    cur_last_d  = 1'b0;
                    last_seen_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (send_bit) begin
            line_upd = 1'b1;
            if (!data_bit) begin
                nrzi_d = !nrzi_q;
                ones_d = '0;
            end else begin
                ones_d = ones_q + OW'(1);
                if (ones_q + OW'(1) == ONES_MAX) begin
                    state_d = STUFF;
                end
            end
        end

        if (line_upd) begin
            d_plus_d  = nrzi_d;
            d_minus_d = !nrzi_d;
        end

        if (accept && state_q != IDLE) begin
            hold_data_d = tx_data;
            hold_full_d = 1'b1;
            hold_last_d = tx_last;
            if (tx_last) begin
                last_seen_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            bits_left_q <= '0;
            ones_q      <= '0;
            eop_cnt_q   <= '0;
            hold_data_q <= '0;
            hold_full_q <= 1'b0;
            hold_last_q <= 1'b0;
            cur_last_q  <= 1'b0;
            last_seen_q <= 1'b0;
            first_q     <= 1'b0;
            nrzi_q      <= 1'b1;
            tx_err_q    <= 1'b0;
            d_plus_q    <= 1'b1;
            d_minus_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            bits_left_q <= bits_left_d;
            ones_q      <= ones_d;
            eop_cnt_q   <= eop_cnt_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
            hold_last_q <= hold_last_d;
            cur_last_q  <= cur_last_d;
            last_seen_q <= last_seen_d;
            first_q     <= first_d;
            nrzi_q      <= nrzi_d;
            tx_err_q    <= tx_err_d;
            d_plus_q    <= d_plus_d;
            d_minus_q   <= d_minus_d;
        end
    end

endmodule

// File: tb/tb_usb_nrzi_tx.sv
// tb/tb_usb_nrzi_tx.sv - table-driven packet vectors plus reset/backpressure sequences for usb_nrzi_tx
module tb_usb_nrzi_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_err;
    logic       d_plus;
    logic       d_minus;

    always #5 clk = ~clk;

    usb_nrzi_tx #(
        .DATA_WIDTH  (8),
        .CLKS_PER_BIT(CPB),
        .STUFF_LEN   (6),
        .EOP_SE0_BITS(2)
    ) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_last (tx_last),
        .tx_ready(tx_ready),
        .tx_busy (tx_busy),
        .tx_err  (tx_err),
        .d_plus  (d_plus),
        .d_minus (d_minus)
    );

    typedef struct packed {
        logic [2:0]  nwords;
        logic [31:0] words;   // word i at [8*i +: 8], last word carries tx_last
        logic        err;
    } vec_t;

    vec_t  vecs [6];
    string syms [6];   // one symbol per bit time: J, K, S(E0)

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_str(input string name, input string got, input string exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %s expected %s", name, got, exp);
        end
    endtask

    function automatic string sym();
        if (d_plus && !d_minus)       return "J";
        else if (!d_plus && d_minus)  return "K";
        else if (!d_plus && !d_minus) return "S";
        else                          return "?";
    endfunction

    task automatic run_vec(input int idx);
        vec_t  v;
        string got, exp, nm;
        int    w, accepts, stalls, err_idx, exp_err_idx;
        bit    started, done;
        v = vecs[idx];
        got = ""; exp = "J";
        w = 0; accepts = 0; stalls = 0; err_idx = -1; exp_err_idx = -1;
        started = 1'b0; done = 1'b0;
        for (int i = 0; i < syms[idx].len(); i++) begin
            for (int k = 0; k < CPB; k++) exp = $sformatf("%s%c", exp, syms[idx][i]);
            if (v.err && exp_err_idx < 0 && syms[idx][i] == "S") exp_err_idx = 1 + CPB * i;
        end
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            @(negedge clk);
            if (started) begin
                if (!tx_busy) begin
                    done = 1'b1;
                end else begin
                    got = {got, sym()};
                    if (tx_err && err_idx < 0) err_idx = got.len() - 1;
                end
            end
            if (w < int'(v.nwords)) begin
                tx_valid = 1'b1;
                tx_data  = v.words[8*w +: 8];
                tx_last  = (w == int'(v.nwords) - 1);
                if (tx_ready) begin
                    w++;
                    accepts++;
                    started = 1'b1;
                end else begin
                    stalls++;
                end
            end else begin
                tx_valid = 1'b0;
                tx_data  = 8'h00;
                tx_last  = 1'b0;
            end
        end
        nm = $sformatf("vec%0d", idx);
        check({nm, "_done"}, int'(done), 1);
        check({nm, "_accepts"}, accepts, int'(v.nwords));
        check_str({nm, "_line"}, got, exp);
        check({nm, "_err_idx"}, err_idx, exp_err_idx);
        if (v.nwords > 3'd2) check({nm, "_stalled"}, int'(stalls > 0), 1);
    endtask

    initial begin
        vecs[0] = '{nwords: 3'd1, words: 32'h0000_0080, err: 1'b0};
        syms[0] = "KJKJKJKKSSJ";
        vecs[1] = '{nwords: 3'd2, words: 32'h0000_00FF, err: 1'b0};
        syms[1] = "JJJJJJKKKJKJKJKJKSSJ";
        vecs[2] = '{nwords: 3'd2, words: 32'h0000_03F0, err: 1'b0};
        syms[2] = "KJKJJJJJJJKJKJKJKSSJ";
        vecs[3] = '{nwords: 3'd0, words: 32'h0000_0055, err: 1'b1};
        syms[3] = "JKKJJKKJSSJ";
        vecs[4] = '{nwords: 3'd4, words: 32'h0804_0201, err: 1'b0};
        syms[4] = "JKJKJKJKJJKJKJKJKJJKJKJKJKJJKJKJSSJ";
        vecs[5] = '{nwords: 3'd1, words: 32'h0000_000F, err: 1'b0};
        syms[5] = "JJJJKJKJSSJ";
        // Underrun vector: one non-last word. nwords=1 but tx_last must be 0,
        // so it is driven by a dedicated flag below.
        vecs[3].nwords = 3'd1;

        n_rst = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dplus",  int'(d_plus),   1);
        check("rst_dminus", int'(d_minus),  0);
        check("rst_ready",  int'(tx_ready), 1);
        check("rst_busy",   int'(tx_busy),  0);
        check("rst_err",    int'(tx_err),   0);
        n_rst = 1'b1;
        @(negedge clk);

        run_vec(0);
        run_vec(1);
        run_vec(2);
        run_vec(4);

        // Underrun: 8'h55 without tx_last, then nothing more.
        begin
            string got, exp;
            int    err_idx, err_cnt;
            bit    done;
            got = ""; exp = "J"; err_idx = -1; err_cnt = 0; done = 1'b0;
            for (int i = 0; i < syms[3].len(); i++)
                for (int k = 0; k < CPB; k++) exp = $sformatf("%s%c", exp, syms[3][i]);
            tx_valid = 1'b1; tx_data = 8'h55; tx_last = 1'b0;
            @(negedge clk);
            tx_valid = 1'b0; tx_data = 8'h00;
            for (int cyc = 0; cyc < 500 && !done; cyc++) begin
                if (!tx_busy) begin
                    done = 1'b1;
                end else begin
                    got = {got, sym()};
                    if (tx_err) begin
                        err_cnt++;
                        if (err_idx < 0) err_idx = got.len() - 1;
                    end
                    @(negedge clk);
                end
            end
            check("under_done", int'(done), 1);
            check_str("under_line", got, exp);
            check("under_err_idx", err_idx, 1 + 8 * CPB);
            check("under_err_cnt", err_cnt, 1);
            check("under_ready_after", int'(tx_ready), 1);
        end

        // Reset during the third bit of an all-ones word, then a packet that
        // would stuff early if the ones counter survived the reset.
        tx_valid = 1'b1; tx_data = 8'hFF; tx_last = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_busy_before", int'(tx_busy), 1);
        #1 n_rst = 1'b0;
        #1;
        check("mid_dplus",  int'(d_plus),   1);
        check("mid_dminus", int'(d_minus),  0);
        check("mid_ready",  int'(tx_ready), 1);
        check("mid_busy",   int'(tx_busy),  0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        run_vec(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
